// File: rtl/muldiv_pkg.sv
// Shared decode constants and FSM encoding for the iterative
// multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] ALUOP_R = 2'b00;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring
// subtract step per cycle on operand magnitudes, signs fixed at the end.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] p_hi_q, p_hi_d;
    logic [WIDTH-1:0] p_lo_q, p_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             div_q, div_d;
    logic             divz_q, divz_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             done_q, done_d;

    logic             is_r;
    logic             is_md;
    logic             is_mv;
    logic             is_div;
    logic             is_sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        is_r   = (ALUOp == ALUOP_R);
        is_md  = (funct == F_MULT) || (funct == F_MULTU) ||
                 (funct == F_DIV)  || (funct == F_DIVU);
        is_mv  = (funct == F_MFHI) || (funct == F_MTHI) ||
                 (funct == F_MFLO) || (funct == F_MTLO);
        is_div = (funct == F_DIV) || (funct == F_DIVU);
        is_sgn = (funct == F_MULT) || (funct == F_DIV);
        a_neg  = is_sgn & a[WIDTH-1];
        b_neg  = is_sgn & b[WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
    end

    // Datapath step candidates, derived only from registered state
    always_comb begin
        sum     = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, opnd_q} : '0);
        shifted = {p_hi_q, p_lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_q};
        prod    = {p_hi_q, p_lo_q};
        if (neg_res_q) begin
            prod = -prod;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        p_hi_d    = p_hi_q;
        p_lo_d    = p_lo_q;
        opnd_d    = opnd_q;
        div_d     = div_q;
        divz_d    = divz_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!flush && start && is_r) begin
                    if (is_md) begin
                        div_d     = is_div;
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        p_hi_d    = '0;
                        p_lo_d    = is_div ? a_mag : b_mag;
                        opnd_d    = is_div ? b_mag : a_mag;
                        divz_d    = 1'b0;
                        cnt_d     = CW'(WIDTH);
                        state_d   = S_RUN;
                        if (is_div && (b == '0)) begin
                            divz_d  = 1'b1;
                            p_hi_d  = a;
                            cnt_d   = '0;
                            state_d = S_FIN;
                        end
                    end else if (funct == F_MTHI) begin
                        hi_d = a;
                    end else if (funct == F_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            S_RUN: begin
                if (flush) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    if (div_q) begin
                        if (!diff[WIDTH]) begin
                            p_hi_d = diff[WIDTH-1:0];
                            p_lo_d = {p_lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            p_hi_d = shifted[WIDTH-1:0];
                            p_lo_d = {p_lo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        p_hi_d = sum[WIDTH:1];
                        p_lo_d = {sum[0], p_lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!div_q) begin
                        {hi_d, lo_d} = prod;
                    end else if (divz_q) begin
                        hi_d = p_hi_q;
                        lo_d = '1;
                    end else begin
                        lo_d = neg_res_q ? -p_lo_q : p_lo_q;
                        hi_d = neg_rem_q ? -p_hi_q : p_hi_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            p_hi_q    <= '0;
            p_lo_q    <= '0;
            opnd_q    <= '0;
            div_q     <= 1'b0;
            divz_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            p_hi_q    <= p_hi_d;
            p_lo_q    <= p_lo_d;
            opnd_q    <= opnd_d;
            div_q     <= div_d;
            divz_q    <= divz_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign rd_data = (funct == F_MFHI) ? hi_q : lo_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign stall   = start & is_r & (is_md | is_mv) & busy;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
// Latency is counted inclusive of the acceptance cycle.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   ALUOp;
    logic [5:0]   funct;
    logic         flush;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] rd_data;
    logic         busy;
    logic         done;
    logic         stall;

    int asserts;
    int fails;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .ALUOp   (ALUOp),
        .funct   (funct),
        .flush   (flush),
        .a       (a),
        .b       (b),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .stall   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input logic [5:0] f, input logic [W-1:0] av,
                         input logic [W-1:0] bv);
        start = 1'b1;
        ALUOp = 2'b00;
        funct = f;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called right after the acceptance edge; lat = -1 on timeout
    task automatic wait_done(output int lat);
        lat = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) return;
        end
        lat = -1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        asserts++;
        if ({hi, lo} !== '0) begin
            fails++;
            $display("FAIL reset_hilo: got %h_%h want 0", hi, lo);
        end
        asserts++;
        if ({busy, done, stall} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: got %b want 000",
                     {busy, done, stall});
        end
    endtask

    task automatic test_mult;
        int lat;
        issue(6'h18, 32'hFFFF_FFFF, 32'd2);
        asserts++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL mult_busy: got %b want 1", busy);
        end
        wait_done(lat);
        asserts++;
        if (lat !== 34) begin
            fails++;
            $display("FAIL mult_latency: got %0d want 34", lat);
        end
        asserts++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
            fails++;
            $display("FAIL mult_res: got %h_%h want ffffffff_fffffffe",
                     hi, lo);
        end
        @(posedge clk);
        #1;
        issue(6'h19, 32'hFFFF_FFFF, 32'd2);
        wait_done(lat);
        asserts++;
        if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE || lat !== 34) begin
            fails++;
            $display("FAIL multu_res: got %h_%h lat %0d want 00000001_fffffffe lat 34",
                     hi, lo, lat);
        end
    endtask

    task automatic test_div;
        int lat;
        issue(6'h1a, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat);
        asserts++;
        if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL div_neg: got hi %h lo %h want ffffffff fffffffd",
                     hi, lo);
        end
        issue(6'h1b, 32'd7, 32'd2);
        wait_done(lat);
        asserts++;
        if (lo !== 32'd3 || hi !== 32'd1) begin
            fails++;
            $display("FAIL divu: got hi %h lo %h want 1 3", hi, lo);
        end
        issue(6'h1a, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        asserts++;
        if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
            fails++;
            $display("FAIL div_ovf: got hi %h lo %h want 0 80000000",
                     hi, lo);
        end
    endtask

    task automatic test_div_zero;
        int lat;
        issue(6'h1a, 32'd5, 32'd0);
        asserts++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL divz_busy: got %b want 1", busy);
        end
        wait_done(lat);
        asserts++;
        if (lat !== 2 || busy !== 1'b0) begin
            fails++;
            $display("FAIL divz_timing: got lat %0d busy %b want 2 0",
                     lat, busy);
        end
        asserts++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'd5) begin
            fails++;
            $display("FAIL divz_res: got hi %h lo %h want 5 ffffffff",
                     hi, lo);
        end
    endtask

    task automatic test_mt;
        issue(6'h11, 32'h11, 32'h0);
        asserts++;
        if (hi !== 32'h11 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL mthi: got hi %h busy %b done %b want 11 0 0",
                     hi, busy, done);
        end
        issue(6'h13, 32'h22, 32'h0);
        asserts++;
        if (lo !== 32'h22 || hi !== 32'h11) begin
            fails++;
            $display("FAIL mtlo: got hi %h lo %h want 11 22", hi, lo);
        end
        funct = 6'h12;
        #1;
        asserts++;
        if (rd_data !== 32'h22) begin
            fails++;
            $display("FAIL mflo_rd: got %h want 22", rd_data);
        end
    endtask

    task automatic test_stall;
        bit seen;
        issue(6'h19, 32'h8000_0000, 32'd4);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        funct = 6'h10;
        #1;
        asserts++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL stall_on: got %b want 1", stall);
        end
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                asserts++;
                if (stall !== 1'b0 || rd_data !== 32'h2) begin
                    fails++;
                    $display("FAIL stall_done: got stall %b rd %h want 0 2",
                             stall, rd_data);
                end
            end else if (stall !== 1'b1) begin
                asserts++;
                fails++;
                $display("FAIL stall_hold: got %b want 1 at cycle %0d",
                         stall, i);
            end
        end
        start = 1'b0;
        asserts++;
        if (!seen) begin
            fails++;
            $display("FAIL stall_timeout: got no done want done");
        end
    endtask

    task automatic test_stalled_mt;
        int lat;
        issue(6'h18, 32'd3, 32'd5);
        issue(6'h11, 32'h99, 32'h0);
        wait_done(lat);
        asserts++;
        if (hi !== 32'h0 || lo !== 32'd15) begin
            fails++;
            $display("FAIL stalled_mthi: got hi %h lo %h want 0 f", hi, lo);
        end
    endtask

    task automatic test_reset_mid;
        bit pulsed;
        issue(6'h1a, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        asserts++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid: got busy %b hi %h lo %h want 0 0 0",
                     busy, hi, lo);
        end
        pulsed = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) pulsed = 1'b1;
        end
        asserts++;
        if (pulsed) begin
            fails++;
            $display("FAIL reset_mid_done: got done pulse want none");
        end
    endtask

    task automatic test_flush;
        int lat;
        issue(6'h11, 32'h11, 32'h0);
        issue(6'h13, 32'h22, 32'h0);
        issue(6'h18, 32'd5, 32'd6);
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        asserts++;
        if (hi !== 32'h11 || lo !== 32'h22 || busy !== 1'b0 ||
            done !== 1'b0) begin
            fails++;
            $display("FAIL flush: got hi %h lo %h busy %b done %b want 11 22 0 0",
                     hi, lo, busy, done);
        end
        issue(6'h19, 32'd5, 32'd6);
        asserts++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL flush_restart: got busy %b want 1", busy);
        end
        wait_done(lat);
        asserts++;
        if (lat !== 34 || lo !== 32'd30 || hi !== 32'd0) begin
            fails++;
            $display("FAIL flush_result: got lat %0d hi %h lo %h want 34 0 1e",
                     lat, hi, lo);
        end
        flush = 1'b1;
        issue(6'h13, 32'h55, 32'h0);
        flush = 1'b0;
        asserts++;
        if (lo !== 32'd30 || busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle_start: got lo %h busy %b want 1e 0",
                     lo, busy);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        issue(6'h19, 32'd9, 32'd9);
        wait_done(lat);
        issue(6'h1b, 32'd7, 32'd2);
        asserts++;
        if (busy !== 1'b1 || lo !== 32'd81) begin
            fails++;
            $display("FAIL b2b_accept: got busy %b lo %h want 1 51", busy, lo);
        end
        wait_done(lat);
        asserts++;
        if (lat !== 34 || lo !== 32'd3 || hi !== 32'd1) begin
            fails++;
            $display("FAIL b2b_result: got lat %0d hi %h lo %h want 34 1 3",
                     lat, hi, lo);
        end
    endtask

    initial begin
        asserts = 0;
        fails   = 0;
        reset   = 1'b1;
        start   = 1'b0;
        ALUOp   = 2'b00;
        funct   = 6'h0;
        flush   = 1'b0;
        a       = '0;
        b       = '0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_mt();
        test_stall();
        test_stalled_mt();
        test_reset_mid();
        test_flush();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule
